oc_dispatch_ctrl: RTL
=====================

# oc_dispatch_ctrl

Parametrised operand-collector dispatch controller between the issue unit and the register-file request FIFO.
- Accepts an issued instruction and allocates a free operand collector (OC) round-robin.
- Translates source register numbers to bank/row addresses through a runtime-writable mapping LUT.
- Emits one or two bank-read requests, splitting same-bank/different-row operand pairs into two beats.
- Tracks OC occupancy until the collector releases.

## Interface
Parameters:
- NUM_OC, 4, number of operand collectors
- NUM_WARP, 8, hardware warps
- REGS_PER_WARP, 8, architectural registers per warp (power of 2, ≥2)
- NUM_BANK, 4, register banks (power of 2, ≥4)
- ROW_W, 3, bank row address width
- SRC_A_LSB, 21, LSB of src A field (REG_W bits) in in_instr
- SRC_B_LSB, 18, LSB of src B field (REG_W bits) in in_instr

Derived widths:
- WARP_W = clog2(NUM_WARP); REG_W = clog2(REGS_PER_WARP)
- BANK_W = clog2(NUM_BANK); BSEL_W = BANK_W-1
- LUT_N = NUM_WARP*REGS_PER_WARP/2; LA_W = clog2(LUT_N)

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- in_valid  in  1  instruction offered
- in_ready  out  1  instruction accepted when in_valid&in_ready
- in_instr  in  32  instruction word
- in_warp  in  WARP_W  hardware warp id
- in_use_b  in  1  instruction reads src B
- oc_release  in  NUM_OC  one-cycle pulse per OC, collector freed
- oc_busy  out  NUM_OC  OC allocated
- cfg_we  in  1  LUT write strobe
- cfg_addr  in  LA_W  LUT entry
- cfg_row  in  ROW_W  row value written
- cfg_bsel  in  BSEL_W  bank-pair select written
- req_valid  out  1  request presented
- req_ready  in  1  request FIFO accepts
- req_ocid  out  clog2(NUM_OC)  destination OC
- req_mask  out  2  bit0 slot A valid, bit1 slot B valid (2'b11 = two-operand enable)
- req_row_a, req_row_b  out  ROW_W  row addresses
- req_bank_a, req_bank_b  out  BANK_W  bank addresses

## Operation
- Address mapping:
  - LUT index = in_warp*(REGS_PER_WARP/2) + (reg>>1).
  - bank = {lut.bsel, reg[0]}; row = lut.row.
- LUT reset contents: entry e has bsel = e mod (NUM_BANK/2) and row = (e div (NUM_BANK/2)) mod 2^ROW_W.
- LUT writes: a cfg_we write is visible to accepts in later cycles only. An accept in the same cycle reads the old value.
- Allocation:
  - Round-robin among OCs with oc_busy=0, searching from pointer ptr (reset 0).
  - On grant to k: ptr <= (k+1) mod NUM_OC and oc_busy[k] <= 1.
  - oc_release[k] clears oc_busy[k] at the next edge. A released OC is eligible from the following cycle.
  - Release of a non-busy OC is ignored.
- in_ready = (any OC free) & (state==IDLE | (state==SEND & req_ready & !split) | (state==SEND_B & req_ready)).
- Split rule: split = in_use_b & bank_a==bank_b & row_a!=row_b.
- Same bank and same row is a single beat with mask 2'b11; one read serves both slots.
- States:
  - IDLE: req_valid=0. On accept → SEND.
  - SEND: req_valid=1.
    - !in_use_b: mask 2'b01.
    - in_use_b & !split: mask 2'b11.
    - split: mask 2'b01.
    - On req_ready: split → SEND_B; accept → SEND (new instruction); else → IDLE.
  - SEND_B: req_valid=1, mask 2'b10, same req_ocid. On req_ready: accept → SEND; else → IDLE.
- Output fields are registered and held stable while req_valid & !req_ready.

## Timing
- Reset values:
  - in_ready: combinational, per the equation above.
  - oc_busy=0, req_valid=0, req_mask=0, req_ocid=0, all rows/banks 0.
  - ptr=0, state IDLE, LUT at reset contents.
- Latency: accept at edge N → request valid in cycle N+1.
- Throughput: 1 instruction/cycle when unsplit and req_ready=1; split costs 1 extra cycle.
- in_ready depends combinationally on req_ready; no other combinational path from inputs to outputs.
- All OCs busy → in_ready=0; any pending request is still presented.
- Reset asserted mid-beat or mid-split drops the request immediately and restores all reset values.

## Structure
- Package gpgpu_oc_pkg: state enum {IDLE, SEND, SEND_B}, LUT entry struct {row, bsel}, default field positions, mask encodings.
- Sub-module oc_rr_alloc: inputs free vector and ptr; outputs grant index and any_free.
- LUT is a flop array inside this block.

## Test plan
- Reset, warp 1, a=3, b=6, use_b=1 → one beat: ocid 0, bank_a 3/row_a 2, bank_b 2/row_b 3, mask 2'b11.
- Warp 0, a=1, b=5, use_b=1 → beat 1: mask 01, bank_a 1/row_a 0. Beat 2: mask 10, bank_b 1/row_b 1, same ocid.
- Five back-to-back accepts, no releases → ocids 0,1,2,3; fifth stalls with in_ready=0. Pulse oc_release[2] → next grant is ocid 2 one cycle later.
- cfg write entry 4 := row 7, bsel 0, in the same cycle as an accept of warp 1 a=0 → old mapping (row 2, bank 0). Repeat next cycle → row 7, bank 0.
- req_ready held 0 for 3 cycles → request fields stable, in_ready=0. Release → next instruction accepted in the same cycle.
- Assert rst mid-split (in SEND_B) → req_valid=0 and oc_busy=0 immediately; LUT back to reset contents.

Source files
------------

// File: rtl/gpgpu_oc_pkg.sv
// Shared types and constants for the operand-collector dispatch path.
package gpgpu_oc_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEND   = 2'd1,
        SEND_B = 2'd2
    } oc_state_e;

    // Default positions of the source register fields in the instruction word.
    localparam int DEF_SRC_A_LSB = 21;
    localparam int DEF_SRC_B_LSB = 18;

    localparam logic [1:0] MASK_NONE = 2'b00;
    localparam logic [1:0] MASK_A    = 2'b01;
    localparam logic [1:0] MASK_B    = 2'b10;
    localparam logic [1:0] MASK_AB   = 2'b11;

endpackage

// File: rtl/oc_dispatch_ctrl_rr_alloc.sv
// Round-robin pick of a free operand collector, searching upward from ptr_i and wrapping.
module oc_rr_alloc #(
    parameter int NUM_OC = 4,
    parameter int OC_W   = 2
) (
    input  logic [NUM_OC-1:0] free_i,
    input  logic [OC_W-1:0]   ptr_i,
    output logic [OC_W-1:0]   grant_o,
    output logic              any_free_o
);

    logic found;

    always_comb begin
        grant_o = '0;
        found   = 1'b0;
        for (int i = 0; i < NUM_OC; i++) begin
            if (!found && free_i[i] && (i >= int'(ptr_i))) begin
                found   = 1'b1;
                grant_o = OC_W'(i);
            end
        end
        // Wrapped part of the search: indices below the pointer.
        for (int i = 0; i < NUM_OC; i++) begin
            if (!found && free_i[i]) begin
                found   = 1'b1;
                grant_o = OC_W'(i);
            end
        end
    end

    assign any_free_o = |free_i;

endmodule

// File: rtl/oc_dispatch_ctrl.sv
// Operand-collector dispatch: allocates an OC round-robin, maps source registers through a
// writable bank/row LUT and emits one or two bank-read beats per instruction.
module oc_dispatch_ctrl
    import gpgpu_oc_pkg::*;
#(
    parameter int NUM_OC        = 4,
    parameter int NUM_WARP      = 8,
    parameter int REGS_PER_WARP = 8,
    parameter int NUM_BANK      = 4,
    parameter int ROW_W         = 3,
    parameter int SRC_A_LSB     = DEF_SRC_A_LSB,
    parameter int SRC_B_LSB     = DEF_SRC_B_LSB,
    localparam int WARP_W = (NUM_WARP > 1) ? $clog2(NUM_WARP) : 1,
    localparam int REG_W  = $clog2(REGS_PER_WARP),
    localparam int BANK_W = $clog2(NUM_BANK),
    localparam int BSEL_W = BANK_W - 1,
    localparam int LUT_N  = NUM_WARP * REGS_PER_WARP / 2,
    localparam int LA_W   = (LUT_N > 1) ? $clog2(LUT_N) : 1,
    localparam int OC_W   = (NUM_OC > 1) ? $clog2(NUM_OC) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [WARP_W-1:0] in_warp,
    input  logic              in_use_b,
    input  logic [NUM_OC-1:0] oc_release,
    output logic [NUM_OC-1:0] oc_busy,
    input  logic              cfg_we,
    input  logic [LA_W-1:0]   cfg_addr,
    input  logic [ROW_W-1:0]  cfg_row,
    input  logic [BSEL_W-1:0] cfg_bsel,
    output logic              req_valid,
    input  logic              req_ready,
    output logic [OC_W-1:0]   req_ocid,
    output logic [1:0]        req_mask,
    output logic [ROW_W-1:0]  req_row_a,
    output logic [ROW_W-1:0]  req_row_b,
    output logic [BANK_W-1:0] req_bank_a,
    output logic [BANK_W-1:0] req_bank_b,
    output logic [1:0]        dbg_state
);

    typedef struct packed {
        logic [ROW_W-1:0]  row;
        logic [BSEL_W-1:0] bsel;
    } lut_entry_t;

    lut_entry_t lut_q [LUT_N];

    oc_state_e         state_q, state_d;
    logic [OC_W-1:0]   ptr_q, ptr_d, ocid_q, ocid_d;
    logic [NUM_OC-1:0] busy_q, busy_d;
    logic [1:0]        mask_q, mask_d;
    logic [ROW_W-1:0]  row_a_q, row_a_d, row_b_q, row_b_d;
    logic [BANK_W-1:0] bank_a_q, bank_a_d, bank_b_q, bank_b_d;
    logic              split_q, split_d;

    logic [REG_W-1:0]  src_a, src_b;
    logic [LA_W-1:0]   idx_a, idx_b;
    lut_entry_t        ent_a, ent_b;
    logic [BANK_W-1:0] map_bank_a, map_bank_b;
    logic              split_new;
    logic [OC_W-1:0]   grant;
    logic              any_free, slot_open, accept;

    assign src_a = in_instr[SRC_A_LSB +: REG_W];
    assign src_b = in_instr[SRC_B_LSB +: REG_W];
    // Adjacent register pairs share one LUT entry; reg[0] picks the bank within the pair.
    assign idx_a = LA_W'(int'(in_warp) * (REGS_PER_WARP / 2) + int'(src_a >> 1));
    assign idx_b = LA_W'(int'(in_warp) * (REGS_PER_WARP / 2) + int'(src_b >> 1));
    assign ent_a = lut_q[idx_a];
    assign ent_b = lut_q[idx_b];
    assign map_bank_a = {ent_a.bsel, src_a[0]};
    assign map_bank_b = {ent_b.bsel, src_b[0]};
    assign split_new  = in_use_b && (map_bank_a == map_bank_b) && (ent_a.row != ent_b.row);

    oc_rr_alloc #(
        .NUM_OC (NUM_OC),
        .OC_W   (OC_W)
    ) u_alloc (
        .free_i     (~busy_q),
        .ptr_i      (ptr_q),
        .grant_o    (grant),
        .any_free_o (any_free)
    );

    // Handshake: a beat transfers on req_valid & req_ready; an instruction is taken on
    // in_valid & in_ready, and only when the current request finishes in this cycle.
    always_comb begin
        slot_open = 1'b0;
        case (state_q)
            IDLE:    slot_open = 1'b1;
            SEND:    slot_open = req_ready && !split_q;
            SEND_B:  slot_open = req_ready;
            default: slot_open = 1'b0;
        endcase
    end

    assign in_ready = any_free && slot_open;
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        busy_d   = busy_q & ~oc_release;
        ocid_d   = ocid_q;
        mask_d   = mask_q;
        row_a_d  = row_a_q;
        row_b_d  = row_b_q;
        bank_a_d = bank_a_q;
        bank_b_d = bank_b_q;
        split_d  = split_q;
        if (accept) begin
            state_d       = SEND;
            ptr_d         = (int'(grant) == NUM_OC - 1) ? '0 : grant + OC_W'(1);
            busy_d[grant] = 1'b1;
            ocid_d        = grant;
            row_a_d       = ent_a.row;
            row_b_d       = ent_b.row;
            bank_a_d      = map_bank_a;
            bank_b_d      = map_bank_b;
            split_d       = split_new;
            mask_d        = (in_use_b && !split_new) ? MASK_AB : MASK_A;
        end else if (req_ready) begin
            case (state_q)
                SEND: begin
                    if (split_q) begin
                        state_d = SEND_B;
                        mask_d  = MASK_B;
                        split_d = 1'b0;
                    end else begin
                        state_d = IDLE;
                        mask_d  = MASK_NONE;
                    end
                end
                SEND_B: begin
                    state_d = IDLE;
                    mask_d  = MASK_NONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            ptr_q    <= '0;
            busy_q   <= '0;
            ocid_q   <= '0;
            mask_q   <= MASK_NONE;
            row_a_q  <= '0;
            row_b_q  <= '0;
            bank_a_q <= '0;
            bank_b_q <= '0;
            split_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            busy_q   <= busy_d;
            ocid_q   <= ocid_d;
            mask_q   <= mask_d;
            row_a_q  <= row_a_d;
            row_b_q  <= row_b_d;
            bank_a_q <= bank_a_d;
            bank_b_q <= bank_b_d;
            split_q  <= split_d;
        end
    end

    // Reset mapping interleaves consecutive entries across bank pairs, then steps the row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < LUT_N; e++) begin
                lut_q[e].bsel <= BSEL_W'(e % (NUM_BANK / 2));
                lut_q[e].row  <= ROW_W'(e / (NUM_BANK / 2));
            end
        end else if (cfg_we && (int'(cfg_addr) < LUT_N)) begin
            lut_q[cfg_addr].row  <= cfg_row;
            lut_q[cfg_addr].bsel <= cfg_bsel;
        end
    end

    assign oc_busy    = busy_q;
    assign req_valid  = (state_q != IDLE);
    assign req_ocid   = ocid_q;
    assign req_mask   = mask_q;
    assign req_row_a  = row_a_q;
    assign req_row_b  = row_b_q;
    assign req_bank_a = bank_a_q;
    assign req_bank_b = bank_b_q;
    assign dbg_state  = state_q;

endmodule
